// File: rtl/hc595_chain_driver.sv
`default_nettype none
// ============================================================================
// Module      : hc595_chain_driver
// Description : Serialises a parallel frame into a daisy chain of 74HC595
//               shift registers. The frame is accepted over a valid/ready
//               handshake and shifted out MSB- or LSB-first on SER/SRCLK, with
//               each SRCLK half-period lasting CLK_DIV system clocks. After the
//               last bit the storage latch (RCLK) is pulsed, the outputs are
//               enabled, and frame_done pulses for one cycle.
// Ports       : s_clk, s_reset     - clock, async active-high reset
//               in_data/valid/ready- frame input handshake
//               ser_out, srclk_out - 595 SER / SRCLK
//               rclk_out, oe_n_out - 595 RCLK / /OE
//               busy, frame_done   - status
// Revision    : 1.0 - initial release
// ============================================================================
module hc595_chain_driver #(
    parameter int NUM_CHIPS = 2,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   s_clk,
    input  logic                   s_reset,
    input  logic [8*NUM_CHIPS-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   ser_out,
    output logic                   srclk_out,
    output logic                   rclk_out,
    output logic                   oe_n_out,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int C_W     = 8 * NUM_CHIPS;
    localparam int C_BIT_W = $clog2(C_W);
    localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [C_BIT_W-1:0] C_BIT_LAST = C_BIT_W'(C_W - 1);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    logic [1:0]         r_state;
    logic [C_W-1:0]     r_shreg;
    logic [C_BIT_W-1:0] r_bit_cnt;
    logic [C_DIV_W-1:0] r_div_cnt;
    logic               r_in_ready;
    logic               r_ser;
    logic               r_srclk;
    logic               r_rclk;
    logic               r_oe_n;
    logic               r_busy;
    logic               r_frame_done;

    logic [1:0]         w_state_nx;
    logic [C_W-1:0]     w_shreg_nx;
    logic [C_W-1:0]     w_shifted;
    logic [C_BIT_W-1:0] w_bit_cnt_nx;
    logic [C_DIV_W-1:0] w_div_cnt_nx;
    logic               w_head_nx;
    logic               w_accept;
    logic               w_phase_end;
    logic               w_last_bit;
    logic               w_in_ready_nx;
    logic               w_ser_nx;
    logic               w_srclk_nx;
    logic               w_rclk_nx;
    logic               w_oe_n_nx;
    logic               w_busy_nx;
    logic               w_done_nx;

    assign w_accept    = in_valid & r_in_ready;
    assign w_phase_end = (r_div_cnt == C_DIV_LAST);
    assign w_last_bit  = (r_bit_cnt == C_BIT_LAST);

    // The head bit is taken from the next-cycle register value so that SER is
    // already valid in the first SETUP cycle after an accept.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head_nx = w_shreg_nx[C_W-1];
            assign w_shifted = {r_shreg[C_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head_nx = w_shreg_nx[0];
            assign w_shifted = {1'b0, r_shreg[C_W-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register (plus datapath registers and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge s_clk or posedge s_reset) begin
        if (s_reset) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_div_cnt    <= '0;
            r_in_ready   <= 1'b0;
            r_ser        <= 1'b0;
            r_srclk      <= 1'b0;
            r_rclk       <= 1'b0;
            r_oe_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_shreg      <= w_shreg_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_div_cnt    <= w_div_cnt_nx;
            r_in_ready   <= w_in_ready_nx;
            r_ser        <= w_ser_nx;
            r_srclk      <= w_srclk_nx;
            r_rclk       <= w_rclk_nx;
            r_oe_n       <= w_oe_n_nx;
            r_busy       <= w_busy_nx;
            r_frame_done <= w_done_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)    w_state_nx = S_SETUP;
            S_SETUP: if (w_phase_end) w_state_nx = S_HIGH;
            S_HIGH:  if (w_phase_end) w_state_nx = w_last_bit ? S_LATCH : S_SETUP;
            S_LATCH: if (w_phase_end) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_shreg_nx   = r_shreg;
        w_bit_cnt_nx = r_bit_cnt;
        w_div_cnt_nx = '0;
        if (r_state == S_IDLE) begin
            if (w_accept) begin
                w_shreg_nx   = in_data;
                w_bit_cnt_nx = '0;
            end
        end else begin
            w_div_cnt_nx = w_phase_end ? '0 : r_div_cnt + 1'b1;
            // Shift happens as SRCLK falls, so SER never moves while SRCLK is high.
            if (r_state == S_HIGH && w_phase_end && !w_last_bit) begin
                w_shreg_nx   = w_shifted;
                w_bit_cnt_nx = r_bit_cnt + 1'b1;
            end
        end

        w_in_ready_nx = (w_state_nx == S_IDLE);
        w_busy_nx     = (w_state_nx != S_IDLE);
        w_srclk_nx    = (w_state_nx == S_HIGH);
        w_rclk_nx     = (w_state_nx == S_LATCH);
        w_ser_nx      = (w_state_nx != S_IDLE) ? w_head_nx : 1'b0;
        w_done_nx     = (r_state == S_LATCH) && (w_state_nx == S_IDLE);
        // Outputs stay enabled once any frame has been latched.
        w_oe_n_nx     = r_oe_n & ~w_done_nx;
    end

    assign in_ready   = r_in_ready;
    assign ser_out    = r_ser;
    assign srclk_out  = r_srclk;
    assign rclk_out   = r_rclk;
    assign oe_n_out   = r_oe_n;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hc595_chain_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_hc595_chain_driver
// Description : Self-checking bench for hc595_chain_driver. Instance 0 uses
//               the default parameters; instance 1 is a 3-chip, CLK_DIV=1,
//               LSB-first chain. A behavioural 595 chain captures SER on each
//               SRCLK rise; on frame_done the captured chain and the frame
//               timing are compared against expected frames queued by the
//               stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hc595_chain_driver;

    logic        s_clk = 1'b0;
    logic        rst0, rst1;
    logic [15:0] data0;
    logic [23:0] data1;
    logic        valid0, valid1;
    logic        rdy0, ser0, srclk0, rclk0, oe_n0, busy0, fd0;
    logic        rdy1, ser1, srclk1, rclk1, oe_n1, busy1, fd1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          id;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    // behavioural chain / monitor state, indexed by instance
    logic [31:0] chain     [2];
    logic        prev_srclk[2];
    logic        prev_rclk [2];
    logic        prev_ser  [2];
    int          edges     [2];
    int          acc_cyc   [2];
    int          rclk_hi   [2];

    hc595_chain_driver dut0 (
        .s_clk(s_clk), .s_reset(rst0), .in_data(data0), .in_valid(valid0),
        .in_ready(rdy0), .ser_out(ser0), .srclk_out(srclk0), .rclk_out(rclk0),
        .oe_n_out(oe_n0), .busy(busy0), .frame_done(fd0)
    );

    hc595_chain_driver #(.NUM_CHIPS(3), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut1 (
        .s_clk(s_clk), .s_reset(rst1), .in_data(data1), .in_valid(valid1),
        .in_ready(rdy1), .ser_out(ser1), .srclk_out(srclk1), .rclk_out(rclk1),
        .oe_n_out(oe_n1), .busy(busy1), .frame_done(fd1)
    );

    always #5 s_clk = ~s_clk;
    always @(posedge s_clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic srclk, input logic rclk, input logic ser,
                       input logic oe_n, input logic fd, input logic busy, input logic rdy,
                       input logic valid, input int w, input int cdiv);
        exp_t        e;
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        if (srclk && !prev_srclk[id]) begin
            chain[id] = {chain[id][30:0], ser};
            edges[id]++;
        end
        if (prev_srclk[id] && srclk && ser !== prev_ser[id]) begin
            errors++;
            $display("FAIL ser_stable[%0d]: ser changed to %0b while srclk high", id, ser);
        end
        if (srclk && rclk) begin
            errors++;
            $display("FAIL overlap[%0d]: srclk=1 rclk=1, required not both", id);
        end
        if (busy && rdy) begin
            errors++;
            $display("FAIL ready_busy[%0d]: in_ready=1 while busy=1", id);
        end
        if (rclk) rclk_hi[id]++;
        if (rclk && !prev_rclk[id])
            chk($sformatf("rclk_offset[%0d]", id), cyc - acc_cyc[id], 2 * w * cdiv);
        if (fd) begin
            if (sb.size() == 0) begin
                chk($sformatf("unexpected_frame[%0d]", id), 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("frame_id[%0d]", id), id, e.id);
                chk($sformatf("latched[%0d]", id), chain[id] & mask, e.val);
            end
            chk($sformatf("srclk_edges[%0d]", id), edges[id], w);
            chk($sformatf("rclk_width[%0d]", id), rclk_hi[id], cdiv);
            chk($sformatf("done_offset[%0d]", id), cyc - acc_cyc[id], 2 * w * cdiv + cdiv);
            chk($sformatf("oe_n_at_done[%0d]", id), oe_n, 0);
        end
        // accept seen now takes effect at the coming rising edge
        if (valid && rdy) begin
            acc_cyc[id] = cyc + 1;
            edges[id]   = 0;
            rclk_hi[id] = 0;
            chain[id]   = '0;
        end
        prev_srclk[id] = srclk;
        prev_rclk[id]  = rclk;
        prev_ser[id]   = ser;
    endtask

    always @(negedge s_clk) begin
        mon(0, srclk0, rclk0, ser0, oe_n0, fd0, busy0, rdy0, valid0, 16, 2);
        mon(1, srclk1, rclk1, ser1, oe_n1, fd1, busy1, rdy1, valid1, 24, 1);
    end

    // stimulus is always applied 2 time units after a rising edge
    task automatic tick();
        @(posedge s_clk);
        #2;
    endtask

    task automatic send0(input logic [15:0] d, input logic [31:0] exp, input bit push, input bit hold);
        int n = 0;
        if (push) sb.push_back('{0, exp});
        data0  = d;
        valid0 = 1'b1;
        while (!rdy0 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("accept_timeout0", 0, 1);
        tick();
        if (!hold) valid0 = 1'b0;
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (!(rdy0 && !busy0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("idle_timeout0", 0, 1);
        repeat (3) tick();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            chain[i] = '0; prev_srclk[i] = 1'b0; prev_rclk[i] = 1'b0; prev_ser[i] = 1'b0;
            edges[i] = 0; acc_cyc[i] = 0; rclk_hi[i] = 0;
        end
        rst0 = 1'b1; rst1 = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0;
        data0 = '0; data1 = '0;

        // reset / idle
        repeat (3) tick();
        chk("rst_ser", ser0, 0);
        chk("rst_srclk", srclk0, 0);
        chk("rst_rclk", rclk0, 0);
        chk("rst_oe_n", oe_n0, 1);
        chk("rst_ready", rdy0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", fd0, 0);
        rst0 = 1'b0; rst1 = 1'b0;
        tick();
        chk("ready_after_reset0", rdy0, 1);
        chk("ready_after_reset1", rdy1, 1);
        repeat (10) tick();
        chk("idle_no_edges", edges[0], 0);
        chk("idle_oe_n", oe_n0, 1);

        // single frame, MSB first: bits 1010 0101 1100 0011
        send0(16'hA5C3, 32'h0000A5C3, 1'b1, 1'b0);
        wait_idle0();

        // back-to-back: valid held, second frame accepted in frame_done cycle
        send0(16'hFFFF, 32'h0000FFFF, 1'b1, 1'b1);
        send0(16'h0000, 32'h00000000, 1'b1, 1'b0);
        wait_idle0();

        // reset mid-frame after the 5th srclk rise
        send0(16'hFFFF, 32'h0, 1'b0, 1'b0);
        n = 0;
        while (edges[0] < 5 && n < 200) begin
            tick();
            n++;
        end
        chk("mid_reset_reach5", (edges[0] >= 5) ? 1 : 0, 1);
        rst0 = 1'b1;
        #1;
        chk("mid_reset_srclk", srclk0, 0);
        chk("mid_reset_rclk", rclk0, 0);
        chk("mid_reset_ser", ser0, 0);
        chk("mid_reset_oe_n", oe_n0, 1);
        tick();
        tick();
        rst0 = 1'b0;
        repeat (2) tick();
        send0(16'h5A3C, 32'h00005A3C, 1'b1, 1'b0);
        wait_idle0();

        // stall: valid/data toggled while busy must be ignored
        send0(16'h3C96, 32'h00003C96, 1'b1, 1'b0);
        repeat (30) begin
            valid0 = 1'($urandom_range(0, 1));
            data0  = 16'($urandom);
            tick();
        end
        valid0 = 1'b0;
        wait_idle0();

        // LSB first, 3 chips, CLK_DIV=1: first bit 1 lands at the far end
        sb.push_back('{1, 32'h00800000});
        data1  = 24'h000001;
        valid1 = 1'b1;
        n = 0;
        while (!rdy1 && n < 100) begin
            tick();
            n++;
        end
        tick();
        valid1 = 1'b0;
        n = 0;
        while (!(rdy1 && !busy1) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("idle_timeout1", 0, 1);
        repeat (3) tick();

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hc595_chain_driver.md
Name: hc595_chain_driver

Overview:
Serial driver for a daisy chain of NUM_CHIPS 74HC595 shift registers. It accepts a parallel frame over a valid/ready handshake and shifts it out MSB- or LSB-first on ser_out/srclk_out at a programmable rate. It then pulses the storage latch and enables the outputs once the first frame is valid. It sits between the display/LED data source and the board-level 595 pins, and replaces the fixed 16-bit free-running driver.

Parameters:
NUM_CHIPS, 2, number of cascaded 595s; frame width W = 8*NUM_CHIPS.
CLK_DIV, 2, s_clk cycles per SRCLK half-period; legal range >=1.
MSB_FIRST, 1, 1: in_data[W-1] shifted first; 0: in_data[0] shifted first.

Ports:
s_clk  input  1  system clock, all logic on rising edge.
s_reset  input  1  reset: s_reset, asynchronous, active-high; clock s_clk.
in_data  input  W  frame to display; sampled on accept.
in_valid  input  1  producer has a frame.
in_ready  output  1  driver can accept a frame.
ser_out  output  1  to 595 SER.
srclk_out  output  1  to 595 SRCLK.
rclk_out  output  1  to 595 RCLK (latch).
oe_n_out  output  1  to 595 /OE; high until the first frame is latched.
busy  output  1  frame in progress (= not IDLE).
frame_done  output  1  one-cycle pulse after the latch completes.

Behaviour:
- All outputs registered. Reset values: ser_out=0, srclk_out=0, rclk_out=0, oe_n_out=1, in_ready=0, busy=0, frame_done=0; state=IDLE, counters=0, shift register=0.
- First cycle after reset release: in_ready=1 (IDLE).
- Accept: in_valid & in_ready at a rising edge. The frame is copied into the internal shift register, bit_cnt=0, and the FSM moves to SETUP. in_ready drops the next cycle.
- in_valid while busy is ignored; the producer holds data per the handshake.
- div_cnt counts 0..CLK_DIV-1 in every non-IDLE state. Each phase lasts exactly CLK_DIV cycles; the phase ends when div_cnt==CLK_DIV-1.
- FSM states:
  IDLE: srclk=0, rclk=0, in_ready=1.
  SETUP: srclk=0. ser_out = current head bit (shreg[W-1] if MSB_FIRST, else shreg[0]), valid from the first SETUP cycle. Goes to HIGH.
  HIGH: srclk=1, ser_out stable. At phase end: if bit_cnt==W-1, go to LATCH; else shift the register by one toward the head, bit_cnt+1, go to SETUP.
  LATCH: srclk=0, rclk=1. At phase end: go to IDLE, rclk=0, oe_n_out=0 (sticky until reset), frame_done=1 for exactly one cycle.
- Timing:
  Frame length after accept = 2*W*CLK_DIV + CLK_DIV cycles.
  Minimum accept-to-accept spacing = that length + 1. Back-to-back accept is allowed in the IDLE cycle where frame_done=1.
- Data never changes while srclk_out=1. rclk_out never overlaps srclk_out=1.
- Mapping: with MSB_FIRST=1, in_data[W-1:W-8] lands on the chip farthest from the driver and in_data[7:0] on the nearest chip.
- Width rules: bit_cnt width = clog2(W); div_cnt width = clog2(CLK_DIV) (min 1). No wrap occurs because the bit count is terminated at W-1.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). The partial frame is discarded, no latch occurs, and oe_n_out returns to 1.
- CLK_DIV=1: each phase is one cycle; the behaviour is otherwise identical.

Test Plan:
- Reset/idle: assert s_reset for 3 cycles, release -> all outputs 0 except oe_n_out=1; in_ready=1 on the first post-reset cycle; no srclk edges while in_valid=0.
- Single frame, defaults: in_data=16'hA5C3, one-cycle valid -> exactly 16 srclk rising edges; ser_out sampled at each rise = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; rclk high for 2 cycles starting 64 cycles after accept; frame_done 66 cycles after accept; oe_n_out falls with frame_done.
- LSB-first, NUM_CHIPS=3, CLK_DIV=1: in_data=24'h000001 -> first sampled bit 1, then 23 zeros; 24 srclk pulses; frame length 49 cycles.
- Back-to-back: in_valid held high with 16'hFFFF then 16'h0000 -> second accept in the frame_done cycle; second frame shifts 16 zeros; rclk pulses twice; in_ready low throughout both frames.
- Reset mid-frame: s_reset asserted after the 5th srclk rise -> same cycle srclk/rclk/ser_out=0, oe_n_out=1; no rclk pulse; next frame after release shifts all 16 bits correctly.
- Stall: in_valid toggled while busy with different data -> ignored; the latched frame equals the originally accepted data.
